mul_div_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit for the MIPS datapath. Implements MULT, MULTU, DIV and DIVU, and holds the HI/LO result registers. Hi and Lo feed two inputs of the 8-way 32-bit ALU result selector; MFHI and MFLO read them through that selector. The control unit drives Start/Op and stalls the pipeline on Busy.

---
 rtl/mul_div_unit.sv | 133 +++++++++++++
 tb/tb_mul_div_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU) holding the HI/LO registers.
// Define MULDIV_HILO_WRITE_EN to add the MTHI/MTLO write ports Hi_We, Lo_We and Wr_Data.
module mul_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef MULDIV_HILO_WRITE_EN
   input  logic             Hi_We,
   input  logic             Lo_We,
   input  logic [WIDTH-1:0] Wr_Data,
`endif
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

   state_e             state_q;
   logic [1:0]         op_q;      // [1]: divide, [0]: signed
   logic               sign_a_q;
   logic               sign_b_q;
   logic               b_zero_q;
   logic [WIDTH-1:0]   mag_b_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_cand;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      sign_a   = Op[0] & A[WIDTH-1];
      sign_b   = Op[0] & B[WIDTH-1];
      mag_a    = sign_a ? -A : A;
      mag_b    = sign_b ? -B : B;
      // Multiply: multiplier sits in the low half and is consumed LSB first.
      addend   = acc_q[0] ? mag_b_q : '0;
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      // Divide: partial remainder shifted left with the next dividend bit.
      div_cand = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_cand - {1'b0, mag_b_q};
      if (!op_q[1]) begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
      end
      prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= StIdle;
         op_q      <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         b_zero_q  <= 1'b0;
         mag_b_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         Hi        <= '0;
         Lo        <= '0;
      end else begin
         Done      <= 1'b0;
         DivByZero <= 1'b0;
`ifdef MULDIV_HILO_WRITE_EN
         if (!Busy) begin
            if (Hi_We) Hi <= Wr_Data;
            if (Lo_We) Lo <= Wr_Data;
         end
`endif
         case (state_q)
            StIdle: begin
               if (Start) begin
                  op_q     <= Op;
                  sign_a_q <= sign_a;
                  sign_b_q <= sign_b;
                  b_zero_q <= (B == '0);
                  mag_b_q  <= mag_b;
                  acc_q    <= {{WIDTH{1'b0}}, mag_a};
                  cnt_q    <= '0;
                  Busy     <= 1'b1;
                  state_q  <= StCalc;
               end
            end
            StCalc: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= StFin;
            end
            StFin: begin
               if (op_q[1]) begin
                  // A zero divisor leaves the dividend as remainder, so Hi already equals A.
                  Hi        <= rem_fix;
                  Lo        <= b_zero_q ? '1 : quot_fix;
                  DivByZero <= b_zero_q;
               end else begin
                  {Hi, Lo} <= prod;
               end
               Done    <= 1'b1;
               Busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

   localparam int unsigned WIDTH = 32;

   logic              Clk;
   logic              Reset;
   logic              Start;
   logic [1:0]        Op;
   logic [WIDTH-1:0]  A;
   logic [WIDTH-1:0]  B;
`ifdef MULDIV_HILO_WRITE_EN
   logic              Hi_We;
   logic              Lo_We;
   logic [WIDTH-1:0]  Wr_Data;
`endif
   logic              Busy;
   logic              Done;
   logic              DivByZero;
   logic [WIDTH-1:0]  Hi;
   logic [WIDTH-1:0]  Lo;

   int checks = 0;
   int errors = 0;

   mul_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Op        (Op),
      .A         (A),
      .B         (B),
`ifdef MULDIV_HILO_WRITE_EN
      .Hi_We     (Hi_We),
      .Lo_We     (Lo_We),
      .Wr_Data   (Wr_Data),
`endif
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   localparam logic [1:0]  DIR_OP  [0:7] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11,
                                             2'b10, 2'b11};
   localparam logic [31:0] DIR_A   [0:7] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000,
                                             32'hFFFFFFF9, 32'd100, 32'h80000000,
                                             32'h12345678, 32'hFFFFFFF0};
   localparam logic [31:0] DIR_B   [0:7] = '{32'hFFFFFFFF, 32'd6, 32'h80000000, 32'd2,
                                             32'd7, 32'hFFFFFFFF, 32'd0, 32'd0};
   localparam logic [31:0] DIR_HI  [0:7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000,
                                             32'hFFFFFFFF, 32'd2, 32'd0, 32'h12345678,
                                             32'hFFFFFFF0};
   localparam logic [31:0] DIR_LO  [0:7] = '{32'h00000001, 32'hFFFFFFD6, 32'h00000000,
                                             32'hFFFFFFFD, 32'd14, 32'h80000000,
                                             32'hFFFFFFFF, 32'hFFFFFFFF};
   localparam logic        DIR_DBZ [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
   function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo, output logic dbz);
      longint sa, sb, ua, ub, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      dbz = 1'b0;
      if (op == 2'b00) begin
         p  = ua * ub;
         hi = p[63:32];
         lo = p[31:0];
      end else if (op == 2'b01) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         dbz = 1'b1;
         hi  = a;
         lo  = 32'hFFFFFFFF;
      end else begin
         if (op == 2'b10) begin
            q = ua / ub;
            r = ua % ub;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
         lo = q[31:0];
         hi = r[31:0];
      end
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h00000000;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   // Caller sits at a negedge; Start is sampled at the following posedge (edge N).
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      Op    = 2'($urandom_range(0, 3));
      A     = $urandom();
      B     = $urandom();
   endtask

   // Counts cycles after edge N; lat is the cycle index in which Done is seen, -1 on timeout.
   task automatic wait_done(input int k0, output int lat, output bit busy_ok);
      int k;
      k       = k0;
      lat     = -1;
      busy_ok = 1'b1;
      while (k < 80) begin
         @(negedge Clk);
         k++;
         if (Done === 1'b1) begin
            lat = k;
            if (Busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (Busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Start = 1'b0;
      Op    = 2'b00;
      A     = '0;
      B     = '0;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      checks++;
      if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
      checks++;
      if (DivByZero !== 1'b0) begin
         errors++; $display("FAIL reset_dbz: got %b expected 0", DivByZero);
      end
      checks++;
      if (Hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", Hi); end
      checks++;
      if (Lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", Lo); end
   endtask

   task automatic test_directed();
      int lat;
      bit busy_ok;
      for (int i = 0; i < 8; i++) begin
         launch(DIR_OP[i], DIR_A[i], DIR_B[i]);
         wait_done(0, lat, busy_ok);
         checks++;
         if (lat != 34) begin errors++; $display("FAIL dir_lat[%0d]: got %0d expected 34", i, lat); end
         checks++;
         if (!busy_ok) begin errors++; $display("FAIL dir_busy[%0d]: got bad profile expected ok", i); end
         checks++;
         if (Hi !== DIR_HI[i]) begin
            errors++; $display("FAIL dir_hi[%0d]: got %h expected %h", i, Hi, DIR_HI[i]);
         end
         checks++;
         if (Lo !== DIR_LO[i]) begin
            errors++; $display("FAIL dir_lo[%0d]: got %h expected %h", i, Lo, DIR_LO[i]);
         end
         checks++;
         if (DivByZero !== DIR_DBZ[i]) begin
            errors++; $display("FAIL dir_dbz[%0d]: got %b expected %b", i, DivByZero, DIR_DBZ[i]);
         end
         @(negedge Clk);
         checks++;
         if (Done !== 1'b0 || DivByZero !== 1'b0) begin
            errors++; $display("FAIL dir_pulse[%0d]: got done=%b dbz=%b expected 0/0", i, Done,
                               DivByZero);
         end
         checks++;
         if (Hi !== DIR_HI[i] || Lo !== DIR_LO[i]) begin
            errors++; $display("FAIL dir_hold[%0d]: got %h/%h expected %h/%h", i, Hi, Lo,
                               DIR_HI[i], DIR_LO[i]);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      bit busy_ok;
      logic [1:0] op;
      logic [31:0] a, b, ehi, elo;
      logic edbz;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         ref_model(op, a, b, ehi, elo, edbz);
         launch(op, a, b);
         wait_done(0, lat, busy_ok);
         checks++;
         if (lat != 34 || !busy_ok) begin
            errors++; $display("FAIL rand_timing[%0d]: got lat=%0d busy_ok=%b expected 34/1", i,
                               lat, busy_ok);
         end
         checks++;
         if (Hi !== ehi || Lo !== elo || DivByZero !== edbz) begin
            errors++;
            $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h/%h/%b expected %h/%h/%b",
                     i, op, a, b, Hi, Lo, DivByZero, ehi, elo, edbz);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      bit busy_ok;
      logic [31:0] ehi, elo;
      logic edbz;
      ref_model(2'b00, 32'h0001_0003, 32'h0000_0101, ehi, elo, edbz);
      launch(2'b00, 32'h0001_0003, 32'h0000_0101);
      repeat (5) @(negedge Clk);
      Start = 1'b1;
      Op    = 2'b10;
      A     = 32'hDEADBEEF;
      B     = 32'd0;
      @(posedge Clk);
      #1 Start = 1'b0;
      wait_done(5, lat, busy_ok);
      checks++;
      if (lat != 34) begin errors++; $display("FAIL ign_lat: got %0d expected 34", lat); end
      checks++;
      if (Hi !== ehi || Lo !== elo || DivByZero !== 1'b0) begin
         errors++; $display("FAIL ign_result: got %h/%h/%b expected %h/%h/0", Hi, Lo, DivByZero,
                            ehi, elo);
      end
      @(negedge Clk);
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL ign_queued: got busy=%b expected 0", Busy); end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit busy_ok;
      logic [31:0] ehi, elo;
      logic edbz;
      launch(2'b01, 32'hFFFFFFF9, 32'd6);
      wait_done(0, lat, busy_ok);
      checks++;
      if (lat != 34 || Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFD6) begin
         errors++; $display("FAIL b2b_first: got lat=%0d %h/%h expected 34 ffffffff/ffffffd6",
                            lat, Hi, Lo);
      end
      ref_model(2'b11, 32'h7FFFFFFF, 32'hFFFFFFFD, ehi, elo, edbz);
      launch(2'b11, 32'h7FFFFFFF, 32'hFFFFFFFD);
      wait_done(0, lat, busy_ok);
      checks++;
      if (lat != 34 || !busy_ok) begin
         errors++; $display("FAIL b2b_lat: got lat=%0d busy_ok=%b expected 34/1", lat, busy_ok);
      end
      checks++;
      if (Hi !== ehi || Lo !== elo) begin
         errors++; $display("FAIL b2b_second: got %h/%h expected %h/%h", Hi, Lo, ehi, elo);
      end
      @(negedge Clk);
   endtask

   task automatic test_reset_mid();
      int lat;
      bit busy_ok;
      int done_seen;
      launch(2'b00, 32'hFFFFFFFF, 32'd2);
      wait_done(0, lat, busy_ok);
      checks++;
      if (Hi !== 32'd1 || Lo !== 32'hFFFFFFFE) begin
         errors++; $display("FAIL rst_pre: got %h/%h expected 00000001/fffffffe", Hi, Lo);
      end
      @(negedge Clk);
      launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (10) @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         errors++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b expected 0/0", Busy, Done);
      end
      checks++;
      if (Hi !== 32'd0 || Lo !== 32'd0) begin
         errors++; $display("FAIL rst_mid_hilo: got %h/%h expected 0/0", Hi, Lo);
      end
      done_seen = 0;
      repeat (40) begin
         @(negedge Clk);
         if (Done === 1'b1 || Busy === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++; $display("FAIL rst_mid_abort: got %0d active cycles expected 0", done_seen);
      end
   endtask

`ifdef MULDIV_HILO_WRITE_EN
   task automatic test_hilo_write();
      int lat;
      bit busy_ok;
      Hi_We   = 1'b1;
      Wr_Data = 32'hA5A5A5A5;
      @(posedge Clk);
      #1 Hi_We = 1'b0;
      @(negedge Clk);
      checks++;
      if (Hi !== 32'hA5A5A5A5 || Lo !== 32'd0) begin
         errors++; $display("FAIL wr_hi: got %h/%h expected a5a5a5a5/00000000", Hi, Lo);
      end
      Hi_We   = 1'b1;
      Lo_We   = 1'b1;
      Wr_Data = 32'h0F0F0F0F;
      @(posedge Clk);
      #1 begin Hi_We = 1'b0; Lo_We = 1'b0; end
      @(negedge Clk);
      checks++;
      if (Hi !== 32'h0F0F0F0F || Lo !== 32'h0F0F0F0F) begin
         errors++; $display("FAIL wr_both: got %h/%h expected 0f0f0f0f/0f0f0f0f", Hi, Lo);
      end
      // Write and Start in the same cycle: write lands, result overwrites later.
      Hi_We   = 1'b1;
      Wr_Data = 32'hA5A5A5A5;
      launch(2'b00, 32'd3, 32'd5);
      Hi_We = 1'b0;
      repeat (3) @(negedge Clk);
      Hi_We   = 1'b1;
      Lo_We   = 1'b1;
      Wr_Data = 32'h12121212;
      @(posedge Clk);
      #1 begin Hi_We = 1'b0; Lo_We = 1'b0; end
      @(negedge Clk);
      checks++;
      if (Hi !== 32'hA5A5A5A5 || Lo !== 32'h0F0F0F0F) begin
         errors++; $display("FAIL wr_busy: got %h/%h expected a5a5a5a5/0f0f0f0f", Hi, Lo);
      end
      wait_done(4, lat, busy_ok);
      checks++;
      if (lat != 34 || Hi !== 32'd0 || Lo !== 32'd15) begin
         errors++; $display("FAIL wr_result: got lat=%0d %h/%h expected 34 0/f", lat, Hi, Lo);
      end
      @(negedge Clk);
   endtask
`endif

   initial begin
`ifdef MULDIV_HILO_WRITE_EN
      Hi_We   = 1'b0;
      Lo_We   = 1'b0;
      Wr_Data = '0;
`endif
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
`ifdef MULDIV_HILO_WRITE_EN
      test_hilo_write();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
